rgmii_rx_framer: RTL

//  Consumes demultiplexed RGMII receive bytes (8-bit data + 2-bit ctl per phy_rx_clk cycle) from the DDR input stage.

---
 rtl/eth_pkg.sv | 39 +++
 rtl/crc32_d8.sv | 12 +
 rtl/rgmii_rx_framer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the RGMII receive framer: FSM states, framing
// constants and the byte-wide reflected CRC-32 helper.
package eth_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    PRE       = 3'd2,
    DATA      = 3'd3,
    DROP      = 3'd4
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  // One byte of the LSB-first (reflected) CRC-32 update, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // The residue constant is written in MSB-first form; the register runs
  // reflected, so it is mirrored before comparison.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h00000000;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 next-state (reflected, poly 0xEDB88320).
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_byte(crc_i, data_i);

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, withholds the 4-byte FCS,
// emits payload bytes with sop/eop/err and counts good/bad frames.
// Optional feature macro: RX_CRC_CHECK_EN (FCS check on received frames).
module rgmii_rx_framer
  import eth_pkg::*;
#(
  parameter int MAX_FRAME = 1522,
  parameter int MIN_FRAME = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic [1:0]  rx_ctl,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  rx_state_e   state_q;
  logic [7:0]  data_q;
  logic        dv_q;
  logic        er_q;
  logic [2:0]  pre_cnt_q;
  logic [15:0] byte_cnt_q;
  logic [7:0]  hb_q [0:3];
  logic [7:0]  la_q;
  logic        la_vld_q;
  logic        first_q;
  logic        er_seen_q;

  logic [15:0] byte_cnt_d;
  logic        crc_bad_s;
  logic        frame_err_s;

  assign byte_cnt_d  = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign frame_err_s = er_seen_q | (byte_cnt_q < 16'(MIN_FRAME)) | crc_bad_s;

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_d;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (data_q),
    .crc_o  (crc_d)
  );

  // Running CRC over every DATA byte; re-seeded whenever no frame is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (state_q == DATA && dv_q) begin
      crc_q <= crc_d;
    end else if (state_q != DATA) begin
      crc_q <= 32'hFFFFFFFF;
    end else begin
      crc_q <= crc_q;
    end
  end

  assign crc_bad_s = (bit_reverse32(crc_q) != CRC32_RESIDUE);
`else
  assign crc_bad_s = 1'b0;
`endif

  // Input register, framing FSM, FCS holdback / lookahead and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_IDLE;
      data_q     <= 8'h00;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      pre_cnt_q  <= 3'd0;
      byte_cnt_q <= 16'd0;
      hb_q[0]    <= 8'h00;
      hb_q[1]    <= 8'h00;
      hb_q[2]    <= 8'h00;
      hb_q[3]    <= 8'h00;
      la_q       <= 8'h00;
      la_vld_q   <= 1'b0;
      first_q    <= 1'b0;
      er_seen_q  <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_err    <= 1'b0;
      frames_ok  <= 16'd0;
      frames_bad <= 16'd0;
    end else begin
      data_q    <= rx_data;
      dv_q      <= rx_ctl[0];
      er_q      <= rx_ctl[0] ^ rx_ctl[1];
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      case (state_q)
        WAIT_IDLE: begin
          if (!dv_q) state_q <= IDLE;
        end
        IDLE: begin
          if (dv_q) begin
            if (data_q == PREAMBLE) begin
              state_q   <= PRE;
              pre_cnt_q <= 3'd1;
            end else begin
              state_q <= DROP;
            end
          end
        end
        PRE: begin
          if (!dv_q) begin
            state_q <= IDLE;
          end else if (data_q == PREAMBLE) begin
            if (pre_cnt_q == 3'd7) state_q <= DROP;
            else                   pre_cnt_q <= pre_cnt_q + 3'd1;
          end else if (data_q == SFD) begin
            state_q    <= DATA;
            byte_cnt_q <= 16'd0;
            la_vld_q   <= 1'b0;
            first_q    <= 1'b1;
            er_seen_q  <= 1'b0;
          end else begin
            state_q <= DROP;
          end
        end
        DATA: begin
          if (!dv_q) begin
            // End of frame: the lookahead byte is the last payload byte.
            state_q  <= IDLE;
            la_vld_q <= 1'b0;
            if (la_vld_q) begin
              out_valid <= 1'b1;
              out_data  <= la_q;
              out_sop   <= first_q;
              out_eop   <= 1'b1;
              out_err   <= frame_err_s;
            end
            if (la_vld_q && !frame_err_s) frames_ok  <= frames_ok + 16'd1;
            else                          frames_bad <= frames_bad + 16'd1;
          end else if (byte_cnt_q == 16'(MAX_FRAME)) begin
            // Oversize: close the frame on the byte already held, drop the rest.
            state_q  <= DROP;
            la_vld_q <= 1'b0;
            if (la_vld_q) begin
              out_valid <= 1'b1;
              out_data  <= la_q;
              out_sop   <= first_q;
              out_eop   <= 1'b1;
              out_err   <= 1'b1;
            end
            frames_bad <= frames_bad + 16'd1;
          end else begin
            byte_cnt_q <= byte_cnt_d;
            er_seen_q  <= er_seen_q | er_q;
            hb_q[0]    <= data_q;
            hb_q[1]    <= hb_q[0];
            hb_q[2]    <= hb_q[1];
            hb_q[3]    <= hb_q[2];
            if (byte_cnt_q >= 16'd4) begin
              la_q     <= hb_q[3];
              la_vld_q <= 1'b1;
            end
            if (la_vld_q) begin
              out_valid <= 1'b1;
              out_data  <= la_q;
              out_sop   <= first_q;
              first_q   <= 1'b0;
            end
          end
        end
        DROP: begin
          if (!dv_q) state_q <= IDLE;
        end
        default: begin
          state_q <= WAIT_IDLE;
        end
      endcase
    end
  end

endmodule
